display_scan_serializer: RTL and testbench

Downstream consumer of the registered 5-to-1 display mux in the solar-panel monitor user project. It owns the mux `select` line and rotates it through the five display channels (voltage, current, power, temperature, efficiency). For each channel it captures the 12-bit mux output and shifts it off-chip as a 16-bit tagged serial frame on three pins (`ser_cs_n`, `ser_sclk`, `ser_mosi`). This replaces the static select tie-off with a continuous, self-timed scan.

---
 rtl/display_scan_serializer.sv | 123 ++++++++++++
 tb/tb_display_scan_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_serializer.sv
// Rotates the display mux select through five channels and shifts each captured
// 12-bit reading out as a 16-bit tagged, odd-parity SPI mode-0 frame.
module display_scan_serializer #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [11:0] data_in,
   output logic [2:0]  select,
   output logic        ser_cs_n,
   output logic        ser_sclk,
   output logic        ser_mosi,
   output logic        frame_done,
   output logic        busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = ($clog2(GAP_CYCLES) > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, LOAD, SHIFT, GAP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [DW-1:0] div_cnt, div_n;
   logic [4:0]    half_cnt, half_n;
   logic [15:0]   shreg, shreg_n;
   logic [2:0]    ch, ch_n;
   logic          done_n;

   assign select = ch;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      div_n   = div_cnt;
      half_n  = half_cnt;
      shreg_n = shreg;
      ch_n    = ch;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_n = SETTLE;
               cnt_n   = '0;
            end
         end
         SETTLE: begin
            // Word is captured on entry to LOAD so bit 15 is already on the pin during LOAD
            if (cnt == CW'(1)) begin
               state_n = LOAD;
               shreg_n = {ch, ~^{ch, data_in}, data_in};
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         LOAD: begin
            state_n = SHIFT;
            div_n   = '0;
            half_n  = '0;
         end
         SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_n = '0;
               if (half_cnt == 5'd31) begin
                  state_n = GAP;
                  cnt_n   = '0;
                  done_n  = 1'b1;
                  ch_n    = (ch == 3'd4) ? 3'd0 : ch + 3'd1;
               end else begin
                  half_n = half_cnt + 5'd1;
                  // Odd half-period ending means sclk falls: present the next bit
                  if (half_cnt[0])
                     shreg_n = {shreg[14:0], 1'b0};
               end
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_n = enable ? SETTLE : IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         div_cnt    <= '0;
         half_cnt   <= '0;
         shreg      <= '0;
         ch         <= '0;
         ser_cs_n   <= 1'b1;
         ser_sclk   <= 1'b0;
         ser_mosi   <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         div_cnt    <= div_n;
         half_cnt   <= half_n;
         shreg      <= shreg_n;
         ch         <= ch_n;
         ser_cs_n   <= !((state_n == LOAD) || (state_n == SHIFT));
         ser_sclk   <= (state_n == SHIFT) && half_n[0];
         ser_mosi   <= ((state_n == LOAD) || (state_n == SHIFT)) && shreg_n[15];
         frame_done <= done_n;
         busy       <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_display_scan_serializer.sv
// Self-checking bench: frame-offset reference model compared every cycle, plus
// literal checks of captured serial words, frame timing and the reset/enable scenarios.
module tb_display_scan_serializer;

   localparam int C  = 4;
   localparam int G  = 8;
   localparam int SH = 3 + 32 * C;   // frame offset of the frame_done cycle
   localparam int FP = SH + G;       // full frame period

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [11:0] data_in = '0;
   logic [2:0]  select;
   logic        ser_cs_n, ser_sclk, ser_mosi, frame_done, busy;

   display_scan_serializer #(.CLK_DIV(C), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
      .select(select), .ser_cs_n(ser_cs_n), .ser_sclk(ser_sclk),
      .ser_mosi(ser_mosi), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] frame_word(input int chn, input logic [11:0] d);
      logic [15:0] w;
      w = {chn[2:0], 1'b0, d};
      if ($countones(w) % 2 == 0) w[12] = 1'b1;
      return w;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: position within the frame as a plain cycle offset
   bit          m_active = 0;
   int          m_o = 0;
   int          m_ch = 0;
   logic [15:0] m_word = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 0; m_o = 0; m_ch = 0;
      end else if (!m_active) begin
         if (enable) begin m_active = 1; m_o = 0; end
      end else begin
         m_o++;
         if (m_o == SH) m_ch = (m_ch + 1) % 5;
         if (m_o == FP) begin
            if (enable) m_o = 0;
            else m_active = 0;
         end
      end
      if (!rst && m_active && m_o == 2) m_word = frame_word(m_ch, data_in);
   end

   logic e_cs, e_sclk, e_mosi, e_fd;
   int   k;
   always @(negedge clk) begin
      if (!rst) begin
         e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_fd = 1'b0;
         if (m_active) begin
            if (m_o == 2) begin
               e_cs = 1'b0; e_mosi = m_word[15];
            end else if (m_o >= 3 && m_o < SH) begin
               k = m_o - 3;
               e_cs = 1'b0;
               e_sclk = ((k / C) % 2) == 1;
               e_mosi = m_word[15 - k / (2 * C)];
            end else if (m_o == SH) begin
               e_fd = 1'b1;
            end
         end
         chk("cycle_outputs", {24'd0, select, ser_cs_n, ser_sclk, ser_mosi, frame_done, busy},
             {24'd0, 3'(m_ch), e_cs, e_sclk, e_mosi, e_fd, m_active});
      end
   end

   // Serial capture: what an SPI mode-0 receiver would see
   logic [15:0] words[$];
   int          lens[$];
   int          starts[$];
   int          nbits = 0, cs_len = 0, fd_cnt = 0;
   bit          in_frame = 0;
   logic [15:0] sh = '0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 0; nbits = 0;
      end else begin
         if (prev_cs && !ser_cs_n) begin
            in_frame = 1; nbits = 0; cs_len = 0; starts.push_back(cyc);
         end
         if (!ser_cs_n) cs_len++;
         if (!prev_sclk && ser_sclk) begin
            sh = {sh[14:0], ser_mosi}; nbits++;
         end
         if (frame_done) fd_cnt++;
         if (!prev_cs && ser_cs_n && in_frame) begin
            chk("frame_bits", nbits, 16);
            words.push_back(sh); lens.push_back(cs_len); in_frame = 0;
         end
      end
      prev_cs = ser_cs_n;
      prev_sclk = ser_sclk;
   end

   // Mux stand-in: fixed values per channel while a word can be captured, noise during shifting
   always @(negedge clk) begin
      if (!ser_cs_n) data_in = 12'($urandom);
      else case (select)
         3'd0:    data_in = 12'h000;
         3'd1:    data_in = 12'h0A5;
         3'd4:    data_in = 12'hFFF;
         default: data_in = 12'($urandom);
      endcase
   end

   task automatic tick();
      @(negedge clk); #2;
   endtask

   task automatic wait_words(input int n, input int budget);
      int i = 0;
      while (words.size() < n && i < budget) begin tick(); i++; end
      chk("wait_words", words.size() >= n, 1);
      if (words.size() < n) begin
         $display("FAIL timeout waiting for frame %0d", n);
         $display("[TB] %0d tests run, %0d failed", tests, failed);
         $fatal(1);
      end
   endtask

   int en_cyc;
   int base;
   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_outputs", {27'd0, select, ser_cs_n, ser_sclk, ser_mosi, frame_done, busy},
          {27'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      repeat (50) tick();
      chk("idle_busy", busy, 0);

      en_cyc = cyc;
      enable = 1'b1;
      wait_words(6, 6 * FP + 50);
      chk("en_to_cs_fall", starts[0] - en_cyc, 3);
      chk("word_ch0", words[0], 16'h1000);
      chk("cs_low_len", lens[0], 129);
      chk("word_ch1", words[1], 16'h20A5);
      chk("tag_ch2", words[2][15:13], 3'd2);
      chk("parity_ch2", $countones(words[2]) % 2, 1);
      chk("tag_ch3", words[3][15:13], 3'd3);
      chk("parity_ch3", $countones(words[3]) % 2, 1);
      chk("word_ch4", words[4], 16'h8FFF);
      chk("word_wrap_ch0", words[5], 16'h1000);
      for (int i = 0; i < 5; i++) chk("frame_spacing", starts[i + 1] - starts[i], FP);
      chk("frame_done_count", fd_cnt, 6);

      begin : drop_enable
         int i = 0;
         while (!(select == 3'd2 && !ser_cs_n && nbits >= 4) && i < 3 * FP) begin tick(); i++; end
         chk("reach_ch2_shift", (select == 3'd2 && !ser_cs_n), 1);
         enable = 1'b0;
         i = 0;
         while (busy && i < 2 * FP) begin tick(); i++; end
         chk("busy_fell", busy, 0);
         chk("select_after_drop", select, 3'd3);
         chk("ch2_frame_completed", words.size(), 8);
         chk("ch2_frame_tag", words[7][15:13], 3'd2);
      end
      repeat (20) tick();
      chk("idle_after_drop", {ser_cs_n, busy}, 2'b10);
      enable = 1'b1;
      wait_words(9, 2 * FP);
      chk("resume_tag", words[8][15:13], 3'd3);

      begin : reset_mid_frame
         int i = 0;
         while (!(in_frame && nbits == 8 && ser_sclk) && i < 3 * FP) begin tick(); i++; end
         chk("reach_bit7_high", (nbits == 8 && ser_sclk), 1);
         #1 rst = 1'b1;
         #1;
         chk("async_reset", {28'd0, select, ser_cs_n, ser_sclk, busy},
             {28'd0, 3'd0, 1'b1, 1'b0, 1'b0});
         repeat (2) tick();
         base = words.size();
         rst = 1'b0;
      end
      wait_words(base + 1, 2 * FP);
      chk("post_reset_word", words[base], 16'h1000);
      chk("post_reset_cs_len", lens[base], 129);
      enable = 1'b0;
      repeat (FP) tick();
      chk("final_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
